btn_debounce: RTL and testbench

- Upstream input stage for the iCESugar LED examples.
- Takes a raw, bouncy push-button pin and synchronises it to the clock, then debounces it.
- Emits a clean level plus single-cycle press, release and long-press events, which drive the blink/LED logic, e.g. selecting the blink rate or toggling the LED enable.

---
 rtl/btn_debounce.sv | 210 +++++++++++++++++++++
 tb/tb_btn_debounce.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: push-button synchroniser and debouncer for the iCESugar LED examples.
// Produces a clean pressed level plus one-cycle press, release, long-press
// and (optionally) auto-repeat strobes.
// Optional feature macro: BTN_AUTOREPEAT_EN enables repeat_pulse generation;
// without it repeat_pulse is tied low and REPEAT_CYCLES only sizes the hold counter.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int REPEAT_CYCLES   = 3000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clki,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  // The IDLE/HELD cycle that first sees the new level counts as the first
  // stable sample, so the wait states accept on their (DEBOUNCE_CYCLES-1)th
  // sample, i.e. when the counter holds DEBOUNCE_CYCLES-2.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  logic [1:0]        sync_q, sync_d;
  logic              act_s;
  state_t            state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_done_q, long_done_d;
  logic              btn_level_q, btn_level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
`ifdef BTN_AUTOREPEAT_EN
  logic              repeat_q, repeat_d;
`endif

  // Synchroniser next value: shift the raw pin into the two-flop chain.
  always_comb begin
    sync_d = {sync_q[0], btn_raw};
  end

  // Synchroniser flops; reset to the released pin level so no false press is seen.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      sync_q <= {2{ACTIVE_LOW}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign act_s = sync_q[1] ^ ACTIVE_LOW;

  // Next-state, counter and strobe logic for the debounce FSM.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    btn_level_d = btn_level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    repeat_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        db_cnt_d = {DB_W{1'b0}};
        if (act_s) begin
          state_d = ST_PRESS_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!act_s) begin
          state_d  = ST_IDLE;
          db_cnt_d = {DB_W{1'b0}};
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = ST_HELD;
          db_cnt_d    = {DB_W{1'b0}};
          hold_cnt_d  = {HOLD_W{1'b0}};
          long_done_d = 1'b0;
          btn_level_d = 1'b1;
          press_d     = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      ST_HELD: begin
        // Hold timing is evaluated before the release check so a long
        // press expiring as the button drops still reports.
        if (!long_done_q) begin
          if (hold_cnt_q == LONG_LAST) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
            hold_cnt_d  = {HOLD_W{1'b0}};
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
          end
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (hold_cnt_q == REP_LAST) begin
            repeat_d   = 1'b1;
            hold_cnt_d = {HOLD_W{1'b0}};
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
          end
`else
          hold_cnt_d = hold_cnt_q;
`endif
        end
        if (!act_s) begin
          state_d  = ST_RELEASE_WAIT;
          db_cnt_d = {DB_W{1'b0}};
        end else begin
          state_d = ST_HELD;
        end
      end
      ST_RELEASE_WAIT: begin
        // Hold counter stays frozen here so a bounce resumes the hold timing.
        if (act_s) begin
          state_d  = ST_HELD;
          db_cnt_d = {DB_W{1'b0}};
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = ST_IDLE;
          db_cnt_d    = {DB_W{1'b0}};
          hold_cnt_d  = {HOLD_W{1'b0}};
          long_done_d = 1'b0;
          btn_level_d = 1'b0;
          release_d   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        db_cnt_d    = {DB_W{1'b0}};
        hold_cnt_d  = {HOLD_W{1'b0}};
        long_done_d = 1'b0;
        btn_level_d = 1'b0;
      end
    endcase
  end

  // FSM state, counters and registered outputs; reset aborts any press silently.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      db_cnt_q    <= {DB_W{1'b0}};
      hold_cnt_q  <= {HOLD_W{1'b0}};
      long_done_q <= 1'b0;
      btn_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      btn_level_q <= btn_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  // Auto-repeat strobe register.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce (DEBOUNCE=4, LONG=16, REPEAT=8, active-low pin).
// Stimulus pushes expected strobe events (cycle, pulse vector, level) into a
// queue; a negedge monitor pops and compares whenever any strobe is high.
module tb_btn_debounce;

  logic clki;
  logic rst;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;

  typedef struct {
    int         cyc;
    logic [3:0] pulses;  // {repeat, long, release, press}
    logic       level;
  } ev_t;

  ev_t exp_q[$];
  int  cyc;
  int  base;
  int  total;
  int  bad;

  localparam logic [3:0] P_PRESS = 4'b0001;
  localparam logic [3:0] P_REL   = 4'b0010;
  localparam logic [3:0] P_LONG  = 4'b0100;
  localparam logic [3:0] P_REP   = 4'b1000;

  btn_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(16),
    .REPEAT_CYCLES(8),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clki(clki),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  // Cycle counter: during cycle n after the reference edge, cyc == base + n.
  always @(posedge clki) cyc <= cyc + 1;

  // Monitor: any strobe must match the next expected event exactly.
  always @(negedge clki) begin
    logic [3:0] p;
    ev_t e;
    p = {repeat_pulse, long_pulse, release_pulse, press_pulse};
    if (p != 4'b0000) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_pulse: got pulses=%b at rel cycle %0d, expected none", p, cyc - base);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.pulses != p || e.level != btn_level) begin
          bad = bad + 1;
          $display("FAIL event: got cyc=%0d pulses=%b level=%b, expected cyc=%0d pulses=%b level=%b",
                   cyc - base, p, btn_level, e.cyc - base, e.pulses, e.level);
        end
      end
    end
  end

  function automatic void expect_ev(int off, logic [3:0] p, logic lvl);
    ev_t e;
    e.cyc    = base + off;
    e.pulses = p;
    e.level  = lvl;
    exp_q.push_back(e);
  endfunction

  // Hold btn_raw at val for n cycles, ending 1 time unit after a posedge.
  task automatic drive(input logic val, input int n);
    btn_raw = val;
    repeat (n) @(posedge clki);
    #1;
  endtask

  task automatic check_idle(input string name);
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL %s_missing: got %0d events outstanding, expected 0 (next at rel cycle %0d)",
               name, exp_q.size(), exp_q[0].cyc - base);
      exp_q.delete();
    end
    total = total + 1;
    if (btn_level !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL %s_level: got %b expected 0", name, btn_level);
    end
  endtask

  task automatic check_zero(input string name);
    logic [4:0] o;
    o = {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse};
    total = total + 1;
    if (o !== 5'b00000) begin
      bad = bad + 1;
      $display("FAIL %s: got outputs=%b expected 00000", name, o);
    end
  endtask

  initial begin
    cyc     = 0;
    base    = 0;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    btn_raw = 1'b1;

    // Reset state, then idle with no pulses.
    repeat (3) @(posedge clki);
    #1;
    check_zero("reset_outputs");
    rst = 1'b0;
    drive(1'b1, 20);
    check_idle("idle_after_reset");

    // Clean press, held past long (and repeats when enabled), then release.
    base = cyc;
    expect_ev(6, P_PRESS, 1'b1);
    expect_ev(22, P_LONG, 1'b1);
`ifdef BTN_AUTOREPEAT_EN
    expect_ev(30, P_REP, 1'b1);
    expect_ev(38, P_REP, 1'b1);
    expect_ev(46, P_REP, 1'b1);
`endif
    expect_ev(53, P_REL, 1'b0);
    drive(1'b0, 47);
    drive(1'b1, 20);
    check_idle("clean_press");

    // Press bounce: 3-cycle glitch, 2 cycles high, then steady low.
    base = cyc;
    expect_ev(11, P_PRESS, 1'b1);
    expect_ev(26, P_REL, 1'b0);
    drive(1'b0, 3);
    drive(1'b1, 2);
    drive(1'b0, 15);
    drive(1'b1, 20);
    check_idle("press_bounce");

    // Release bounce after a long press: one long, one release.
    base = cyc;
    expect_ev(6, P_PRESS, 1'b1);
    expect_ev(22, P_LONG, 1'b1);
    expect_ev(33, P_REL, 1'b0);
    drive(1'b0, 24);
    drive(1'b1, 2);
    drive(1'b0, 1);
    drive(1'b1, 20);
    check_idle("release_bounce");

    // Glitches shorter than the debounce window produce nothing.
    for (int len = 1; len <= 3; len++) begin
      base = cyc;
      drive(1'b0, len);
      drive(1'b1, 12);
      check_idle($sformatf("glitch_%0d", len));
    end

    // Reset during PRESS_WAIT.
    base = cyc;
    drive(1'b0, 4);
    rst = 1'b1;
    #1;
    check_zero("rst_in_press_wait");
    btn_raw = 1'b1;
    drive(1'b1, 2);
    rst = 1'b0;
    drive(1'b1, 20);
    check_idle("after_rst_press_wait");

    // Reset during HELD: level must drop immediately, no release follows.
    base = cyc;
    expect_ev(6, P_PRESS, 1'b1);
    drive(1'b0, 10);
    total = total + 1;
    if (btn_level !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL held_level: got %b expected 1", btn_level);
    end
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_in_held");
    btn_raw = 1'b1;
    drive(1'b1, 2);
    rst = 1'b0;
    drive(1'b1, 20);
    check_idle("after_rst_held");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
